// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one block-wide memory port between the I- and D-cache.
// Optional watchdog on the WAIT state is enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int BLOCK_W        = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [BLOCK_W-1:0] wdata_i,
    input  logic               req_d,
    input  logic               we_d,
    input  logic [ADDR_W-1:0]  addr_d,
    input  logic [BLOCK_W-1:0] wdata_d,
    output logic               gnt_i,
    output logic               gnt_d,
    output logic               done_i,
    output logic               done_d,
    output logic [BLOCK_W-1:0] rdata,
    output logic               err,
    input  logic               ready_mem,
    input  logic               mem_done,
    input  logic [BLOCK_W-1:0] mem_rdata,
    output logic               read_mem,
    output logic               write_mem,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;   // 1 = D-cache
    logic               last_q, last_d;     // last_grant, 1 = D-cache
    logic               lat_we_q, lat_we_d;
    logic [ADDR_W-1:0]  lat_addr_q, lat_addr_d;
    logic [BLOCK_W-1:0] lat_wdata_q, lat_wdata_d;

    logic               gnt_i_q, gnt_i_d;
    logic               gnt_d_q, gnt_d_d;
    logic               done_i_q, done_i_d;
    logic               done_d_q, done_d_d;
    logic [BLOCK_W-1:0] rdata_q, rdata_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  maddr_q, maddr_d;
    logic [BLOCK_W-1:0] mwdata_q, mwdata_d;
    logic               busy_q, busy_d;
    logic               timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
    assign cnt_d   = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    assign timeout = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= timeout && !mem_done;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rdata_d     = rdata_q;
        read_d      = 1'b0;
        write_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    owner_d     = req_d && !(req_i && last_q);
                    lat_we_d    = owner_d ? we_d : we_i;
                    lat_addr_d  = owner_d ? addr_d : addr_i;
                    lat_wdata_d = owner_d ? wdata_d : wdata_i;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (ready_mem) begin
                    read_d  = !lat_we_q;
                    write_d = lat_we_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    rdata_d = lat_we_q ? '0 : mem_rdata;
                    state_d = RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs are decoded from the next state so they line up with it.
        busy_d   = (state_d != IDLE);
        gnt_i_d  = busy_d && !owner_d;
        gnt_d_d  = busy_d && owner_d;
        done_i_d = (state_d == RESP) && !owner_d;
        done_d_d = (state_d == RESP) && owner_d;
        maddr_d  = (state_d == ISSUE || state_d == WAIT) ? lat_addr_d : '0;
        mwdata_d = ((state_d == ISSUE || state_d == WAIT) && lat_we_d) ? lat_wdata_d : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            gnt_i_q     <= 1'b0;
            gnt_d_q     <= 1'b0;
            done_i_q    <= 1'b0;
            done_d_q    <= 1'b0;
            rdata_q     <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            maddr_q     <= '0;
            mwdata_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            gnt_i_q     <= gnt_i_d;
            gnt_d_q     <= gnt_d_d;
            done_i_q    <= done_i_d;
            done_d_q    <= done_d_d;
            rdata_q     <= rdata_d;
            read_q      <= read_d;
            write_q     <= write_d;
            maddr_q     <= maddr_d;
            mwdata_q    <= mwdata_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_i     = gnt_i_q;
    assign gnt_d     = gnt_d_q;
    assign done_i    = done_i_q;
    assign done_d    = done_d_q;
    assign rdata     = rdata_q;
    assign read_mem  = read_q;
    assign write_mem = write_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, reset/timeout sequences and a randomized
// phase checked against a transaction-level model of the round-robin arbiter.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int BW  = 128;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_i, we_i, req_d, we_d;
    logic [AW-1:0] addr_i, addr_d, mem_addr;
    logic [BW-1:0] wdata_i, wdata_d, rdata, mem_rdata, mem_wdata;
    logic          gnt_i, gnt_d, done_i, done_d, err;
    logic          ready_mem, mem_done, read_mem, write_mem, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d),
        .gnt_i(gnt_i), .gnt_d(gnt_d), .done_i(done_i), .done_d(done_d),
        .rdata(rdata), .err(err),
        .ready_mem(ready_mem), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .read_mem(read_mem), .write_mem(write_mem),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
    } port_t;

    port_t pI, pD;
    int    last_g;   // 0 = I, 1 = D

    typedef struct {
        logic ri; logic wi; logic [AW-1:0] ai; logic [BW-1:0] wdi;
        logic rd; logic wd; logic [AW-1:0] ad; logic [BW-1:0] wdd;
        int rdly; int mdly; bit spur; logic [BW-1:0] mrd;
        int exp_own; int exp_dn; logic [BW-1:0] exp_rdata;
    } vec_t;

    vec_t tbl[7];

    task automatic chk1(input string nm, input int cyc, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %b, want %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chka(input string nm, input int cyc, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input int cyc, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm, input int cyc);
        chk1({nm, ".gnt_i"}, cyc, gnt_i, 1'b0);
        chk1({nm, ".gnt_d"}, cyc, gnt_d, 1'b0);
        chk1({nm, ".done_i"}, cyc, done_i, 1'b0);
        chk1({nm, ".done_d"}, cyc, done_d, 1'b0);
        chk1({nm, ".err"}, cyc, err, 1'b0);
        chk1({nm, ".read_mem"}, cyc, read_mem, 1'b0);
        chk1({nm, ".write_mem"}, cyc, write_mem, 1'b0);
        chk1({nm, ".busy"}, cyc, busy, 1'b0);
        chka({nm, ".mem_addr"}, cyc, mem_addr, '0);
        chkw({nm, ".mem_wdata"}, cyc, mem_wdata, '0);
        chkw({nm, ".rdata"}, cyc, rdata, '0);
    endtask

    // One arbitration round, started at a negedge with the current pI/pD requests.
    // Cycle n is the negedge after the n-th rising edge; done is expected at cycle dn.
    task automatic run_txn(input int rdly, input int mdly, input bit spur, input logic [BW-1:0] mrd,
                           input int own, input int dn, input logic [BW-1:0] exp_rd, input bit exp_err);
        port_t p;
        int    dl;
        bit    strobe;
        p = (own == 1) ? pD : pI;
        req_i = pI.req; we_i = pI.we; addr_i = pI.addr; wdata_i = pI.wdata;
        req_d = pD.req; we_d = pD.we; addr_d = pD.addr; wdata_d = pD.wdata;
        mem_done = 1'b0; mem_rdata = mrd; ready_mem = 1'b0;
        dl = -1;
        for (int n = 1; n <= dn + 1; n++) begin
            @(negedge clk);
            chk1("gnt_i", n, gnt_i, own == 0 && n <= dn);
            chk1("gnt_d", n, gnt_d, own == 1 && n <= dn);
            chk1("busy", n, busy, n <= dn);
            chk1("read_mem", n, read_mem, n == 2 + rdly && !p.we);
            chk1("write_mem", n, write_mem, n == 2 + rdly && p.we);
            chka("mem_addr", n, mem_addr, (n < dn) ? p.addr : '0);
            chkw("mem_wdata", n, mem_wdata, (n < dn && p.we) ? p.wdata : '0);
            chk1("done_i", n, done_i, own == 0 && n == dn);
            chk1("done_d", n, done_d, own == 1 && n == dn);
            chk1("err", n, err, exp_err && n == dn);
            if (n == dn) chkw("rdata", n, rdata, exp_rd);

            // Memory: ready after rdly ISSUE cycles, mem_done mdly cycles after the observed strobe.
            strobe    = read_mem || write_mem;
            mem_done  = 1'b0;
            mem_rdata = mrd;
            ready_mem = (n >= 1 + rdly);
            if (strobe && mdly >= 0) dl = mdly;
            if (dl == 0) begin
                mem_done = 1'b1;
                dl = -1;
            end else if (dl > 0) begin
                dl--;
            end
            if (spur && (n == 1 || n == dn)) begin
                mem_done = 1'b1;
                if (n == 1) mem_rdata = ~mrd;
            end
            // Owner's address/data wander after grant; the latched copy must be used.
            if (n == 1) begin
                if (own == 0) begin
                    addr_i = $urandom; wdata_i = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    addr_d = $urandom; wdata_d = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            if (n == dn) begin
                if (own == 0) req_i = 1'b0;
                else          req_d = 1'b0;
            end
        end
        if (own == 1) pD.req = 1'b0;
        else          pI.req = 1'b0;
        last_g = own;
    endtask

    // Reference: single requester wins; on a tie, the one not granted last wins.
    task automatic run_model_txn(input int rdly, input int mdly, input bit spur);
        int            own;
        port_t         p;
        logic [BW-1:0] mrd;
        if (pI.req && pD.req) own = (last_g == 1) ? 0 : 1;
        else                  own = pD.req ? 1 : 0;
        p   = (own == 1) ? pD : pI;
        mrd = {$urandom, $urandom, $urandom, $urandom};
        run_txn(rdly, mdly, spur, mrd, own, 3 + rdly + mdly, p.we ? '0 : mrd, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] db;
        db = {4{32'hDEADBEEF}};
        tbl[0] = '{1'b1, 1'b0, 32'h40, '0, 1'b1, 1'b1, 32'h1230, db, 0, 1, 1'b0,
                   128'h11112222_33334444_55556666_77778888, 0, 4, 128'h11112222_33334444_55556666_77778888};
        tbl[1] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h1230, db, 0, 1, 1'b0,
                   128'hCAFE0000_CAFE0001_CAFE0002_CAFE0003, 1, 4, '0};
        tbl[2] = '{1'b1, 1'b0, 32'h80, '0, 1'b1, 1'b0, 32'h300, '0, 5, 2, 1'b1,
                   128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 10, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        tbl[3] = '{1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h300, '0, 0, 0, 1'b0,
                   128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 1, 3, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0};
        tbl[4] = '{1'b1, 1'b1, 32'h500, {4{32'h55550000}}, 1'b1, 1'b1, 32'h600, {4{32'h66660000}}, 2, 3, 1'b0,
                   128'h1, 0, 8, '0};
        tbl[5] = '{1'b1, 1'b0, 32'h700, '0, 1'b1, 1'b1, 32'h600, {4{32'h66660000}}, 0, 1, 1'b1,
                   128'h2, 1, 4, '0};
        tbl[6] = '{1'b1, 1'b0, 32'h700, '0, 1'b0, 1'b0, '0, '0, 1, 0, 1'b0,
                   128'h77777777_00000000_77777777_00000000, 0, 4, 128'h77777777_00000000_77777777_00000000};

        reset = 1'b1;
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        req_d = 1'b0; we_d = 1'b0; addr_d = '0; wdata_d = '0;
        ready_mem = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        pI = '{1'b0, 1'b0, '0, '0};
        pD = '{1'b0, 1'b0, '0, '0};
        last_g = 1;
        repeat (3) @(negedge clk);
        chk_zero("reset", 0);
        reset = 1'b0;
        @(negedge clk);
        chk_zero("idle", 0);

        for (int i = 0; i < 7; i++) begin
            pI = '{tbl[i].ri, tbl[i].wi, tbl[i].ai, tbl[i].wdi};
            pD = '{tbl[i].rd, tbl[i].wd, tbl[i].ad, tbl[i].wdd};
            run_txn(tbl[i].rdly, tbl[i].mdly, tbl[i].spur, tbl[i].mrd,
                    tbl[i].exp_own, tbl[i].exp_dn, tbl[i].exp_rdata, 1'b0);
        end

        // Reset while waiting for memory, followed by a stale mem_done.
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h44; wdata_i = '0;
        req_d = 1'b0; ready_mem = 1'b1; mem_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("pre_reset.read_mem", 2, read_mem, 1'b1);
        @(negedge clk);
        chk1("pre_reset.busy", 3, busy, 1'b1);
        reset = 1'b1;
        req_i = 1'b0;
        #1;
        chk_zero("mid_reset", 3);
        @(negedge clk);
        reset = 1'b0;
        mem_done = 1'b1;
        mem_rdata = {4{32'hBAD0BAD0}};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_zero("post_reset", k);
            mem_done = 1'b0;
        end
        pI = '{1'b0, 1'b0, '0, '0};
        pD = '{1'b0, 1'b0, '0, '0};
        last_g = 1;

        pI = '{1'b1, 1'b0, 32'h48, '0};
        pD = '{1'b1, 1'b1, 32'h2000, {4{32'h12345678}}};
        run_txn(0, 1, 1'b0, 128'h8888_7777_6666_5555_4444_3333_2222_1111, 0, 4,
                128'h8888_7777_6666_5555_4444_3333_2222_1111, 1'b0);

        for (int t = 0; t < 40; t++) begin
            if (!pI.req && $urandom_range(0, 2) != 0)
                pI = '{1'b1, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom}};
            if (!pD.req && $urandom_range(0, 2) != 0)
                pD = '{1'b1, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom}};
            if (!pI.req && !pD.req)
                pI = '{1'b1, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom}};
            run_model_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 2; k++) begin
            if (pI.req || pD.req) run_model_txn(0, 1, 1'b0);
        end

`ifdef ARB_TIMEOUT_EN
        pI = '{1'b1, 1'b0, 32'h900, '0};
        run_txn(1, -1, 1'b0, {4{32'h99999999}}, 0, 3 + TMO, '0, 1'b1);
        pD = '{1'b1, 1'b0, 32'hA00, '0};
        run_txn(0, TMO - 1, 1'b0, {4{32'hAAAA5555}}, 1, 2 + TMO, {4{32'hAAAA5555}}, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (I) and the data cache (D).
- Each cache issues block-granular read (refill) or write (write-back / write-through) requests.
- The arbiter selects one requester round-robin, drives the memory handshake (ready_mem / mem_done), and returns a done pulse plus the 128-bit block to the owner.
- It sits between both cache controllers and the memory model.

Parameters:
- ADDR_W, 32, address width.
- BLOCK_W, 128, block width (4 words x 32 bits).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_i  in  1  I-cache request; held high until done_i.
- we_i  in  1  I-cache write-enable (1 = write block); stable while req_i is high.
- addr_i  in  ADDR_W  I-cache block address; stable while req_i is high.
- wdata_i  in  BLOCK_W  I-cache write block; stable while req_i is high.
- req_d, we_d, addr_d, wdata_d  in  1/1/ADDR_W/BLOCK_W  D-cache equivalents.
- gnt_i, gnt_d  out  1  owner indicator; high from ISSUE through RESP.
- done_i, done_d  out  1  one-cycle completion pulse to the owner.
- rdata  out  BLOCK_W  registered read block; valid while done_x is high.
- err  out  1  timeout flag, coincident with done_x.
- ready_mem  in  1  memory able to accept a command.
- mem_done  in  1  memory completed the command (read data valid this cycle).
- mem_rdata  in  BLOCK_W  memory read block.
- read_mem, write_mem  out  1  one-cycle command strobes.
- mem_addr  out  ADDR_W  command address.
- mem_wdata  out  BLOCK_W  command write block.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous. All outputs go to 0, state = IDLE, last_grant = D, so I wins the first tie.
- Reset in any state aborts the transfer immediately; no done pulse is issued.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Neither req high: stay in IDLE.
  - One req high: grant that requester.
  - Both req high: grant the requester that is not last_grant.
  - On grant: latch owner, we, addr and wdata; set gnt_x; go to ISSUE.
- ISSUE:
  - ready_mem = 0: hold in ISSUE.
  - ready_mem = 1: pulse read_mem (we = 0) or write_mem (we = 1) for exactly one cycle; go to WAIT.
  - mem_addr and mem_wdata are driven from the latches from ISSUE entry until leaving WAIT. mem_wdata = 0 for reads.
- WAIT:
  - On mem_done: capture mem_rdata into rdata (reads only; writes load rdata = 0); go to RESP.
  - mem_done arriving in the same cycle as the strobe is accepted.
- RESP:
  - done_x = 1 for one cycle; update last_grant = owner.
  - Next cycle: clear gnt_x and return to IDLE.
  - The requester must drop req_x on the edge that samples done_x.
- Minimum latency, from req sampled high with ready_mem = 1 and mem_done returned in the cycle after the strobe: done at edge 4.
- The losing requester waits without loss; its req stays high.
- A req that rises while another transfer is in progress is considered only in IDLE.
- mem_done received outside WAIT is ignored.
- Changing addr_x or wdata_x after grant has no effect, because the latched values are used.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on WAIT entry and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES without mem_done: go to RESP with rdata = 0 and err = 1 for the done cycle; last_grant still updates.
- Undefined: WAIT lasts indefinitely; err is tied to 0 and no counter logic is synthesized.

Test Plan:
1. Single read from I: req_i = 1, we_i = 0, addr_i = 0x0000_0040, ready_mem = 1; mem_done one cycle after read_mem with mem_rdata = 0x11112222_33334444_55556666_77778888 -> read_mem pulse with mem_addr = 0x40; done_i pulse with rdata = that value; done_d stays 0.
2. Write from D: req_d = 1, we_d = 1, addr_d = 0x0000_1230, wdata_d = 0xDEADBEEF_x4 -> write_mem single pulse with mem_wdata = wdata_d, mem_addr = 0x1230; done_d pulse; rdata = 0.
3. Simultaneous requests after reset: req_i = req_d = 1 -> I served first, then D. Assert both again -> I served again (after D, I is next), showing alternation.
4. Backpressure: ready_mem = 0 for 5 cycles after grant -> read_mem stays 0, busy = 1, strobe fires in the cycle ready_mem rises.
5. Reset mid-WAIT: reset during WAIT, then late mem_done -> all outputs 0, no done pulse, next req_i served normally.
6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, mem_done never asserted -> done_i with err = 1 and rdata = 0 after 8 WAIT cycles; return to IDLE.
